// File: rtl/ps2_key_mapper_if.sv
// Byte-stream in / key-bitmap out bundle between the PS/2 receiver and the key mapper.
interface ps2_key_mapper_if #(
  parameter int OCTAVES = 2
);
  logic                   dataValid;
  logic [7:0]             dataIn;
  logic [12*OCTAVES-1:0]  keys;
  logic                   keyEvent;
  logic [4:0]             eventIndex;
  logic                   eventPress;
  logic [7:0]             lastCode;
  logic [7:0]             prevCode;

  modport master (
    output dataValid, dataIn,
    input  keys, keyEvent, eventIndex, eventPress, lastCode, prevCode
  );

  modport slave (
    input  dataValid, dataIn,
    output keys, keyEvent, eventIndex, eventPress, lastCode, prevCode
  );
endinterface

// File: rtl/ps2_key_mapper.sv
// PS/2 Set-2 scan-code stream to per-note key-held bitmap.
// Handles F0 (break) and E0 (extended) prefixes; extended keys are never mapped.
// Optional macro PS2_KEY_TIMEOUT_EN: auto-release all keys after TIMEOUT_CYCLES idle cycles.
module ps2_key_mapper #(
  parameter int OCTAVES        = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             mclk,
  input  logic             rst,
  ps2_key_mapper_if.slave  bus
);
  localparam int NK = 12 * OCTAVES;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BRK} state_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } noteLookup_t;

  // Set-2 make code to chromatic note index; codes beyond the configured octaves miss.
  function automatic noteLookup_t lookup(input logic [7:0] code);
    noteLookup_t r;
    r.hit = 1'b1;
    r.idx = 5'd0;
    case (code)
      8'h1A: r.idx = 5'd0;   8'h1B: r.idx = 5'd1;   8'h22: r.idx = 5'd2;
      8'h23: r.idx = 5'd3;   8'h21: r.idx = 5'd4;   8'h2A: r.idx = 5'd5;
      8'h34: r.idx = 5'd6;   8'h32: r.idx = 5'd7;   8'h33: r.idx = 5'd8;
      8'h31: r.idx = 5'd9;   8'h3B: r.idx = 5'd10;  8'h3A: r.idx = 5'd11;
      8'h15: r.idx = 5'd12;  8'h1E: r.idx = 5'd13;  8'h1D: r.idx = 5'd14;
      8'h26: r.idx = 5'd15;  8'h24: r.idx = 5'd16;  8'h2D: r.idx = 5'd17;
      8'h2E: r.idx = 5'd18;  8'h2C: r.idx = 5'd19;  8'h36: r.idx = 5'd20;
      8'h35: r.idx = 5'd21;  8'h3D: r.idx = 5'd22;  8'h3C: r.idx = 5'd23;
      default: r.hit = 1'b0;
    endcase
    if (int'(r.idx) >= NK) r.hit = 1'b0;
    return r;
  endfunction

  state_t          state;
  logic [NK-1:0]   keysQ;
  logic            keyEventQ;
  logic [4:0]      eventIndexQ;
  logic            eventPressQ;
  logic [7:0]      lastCodeQ;
  logic [7:0]      prevCodeQ;

  noteLookup_t     look;
  logic [NK-1:0]   selMask;
  logic            held;
  logic            timeoutHit;

  // Decode the incoming byte and test whether its note is currently held.
  always_comb begin
    look    = lookup(bus.dataIn);
    selMask = {{(NK-1){1'b0}}, 1'b1} << look.idx;
    held    = |(keysQ & selMask);
  end

`ifdef PS2_KEY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] idleCnt;

  // Idle counter: cleared by any byte, saturates at TIMEOUT_CYCLES.
  always_ff @(posedge mclk) begin
    if (rst || bus.dataValid) idleCnt <= '0;
    else if (idleCnt != TMAX) idleCnt <= idleCnt + 1'b1;
  end

  // Fires on the idle edge that brings the counter to TIMEOUT_CYCLES.
  assign timeoutHit = !bus.dataValid && (idleCnt == TMAX - 1'b1);
`else
  assign timeoutHit = 1'b0;
`endif

  // Prefix FSM, key bitmap, event pulse and raw-byte history; all registered.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state       <= IDLE;
      keysQ       <= '0;
      keyEventQ   <= 1'b0;
      eventIndexQ <= 5'd0;
      eventPressQ <= 1'b0;
      lastCodeQ   <= 8'h00;
      prevCodeQ   <= 8'h00;
    end else begin
      keyEventQ <= 1'b0;
      if (bus.dataValid) begin
        prevCodeQ <= lastCodeQ;
        lastCodeQ <= bus.dataIn;
        unique case (state)
          IDLE: begin
            if (bus.dataIn == 8'hF0)      state <= BREAK;
            else if (bus.dataIn == 8'hE0) state <= EXT;
            else begin
              state <= IDLE;
              // Typematic repeat of a held key is not a transition.
              if (look.hit && !held) begin
                keysQ       <= keysQ | selMask;
                keyEventQ   <= 1'b1;
                eventIndexQ <= look.idx;
                eventPressQ <= 1'b1;
              end
            end
          end
          BREAK: begin
            if (bus.dataIn == 8'hF0)      state <= BREAK;
            else if (bus.dataIn == 8'hE0) state <= EXT_BRK;
            else begin
              state <= IDLE;
              if (look.hit && held) begin
                keysQ       <= keysQ & ~selMask;
                keyEventQ   <= 1'b1;
                eventIndexQ <= look.idx;
                eventPressQ <= 1'b0;
              end
            end
          end
          EXT: begin
            if (bus.dataIn == 8'hF0)      state <= EXT_BRK;
            else if (bus.dataIn == 8'hE0) state <= EXT;
            else                          state <= IDLE;
          end
          EXT_BRK: begin
            if (bus.dataIn == 8'hF0 || bus.dataIn == 8'hE0) state <= EXT_BRK;
            else                                             state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (timeoutHit && keysQ != '0) begin
        // Silent recovery from lost break codes.
        keysQ <= '0;
        state <= IDLE;
      end
    end
  end

  assign bus.keys       = keysQ;
  assign bus.keyEvent   = keyEventQ;
  assign bus.eventIndex = eventIndexQ;
  assign bus.eventPress = eventPressQ;
  assign bus.lastCode   = lastCodeQ;
  assign bus.prevCode   = prevCodeQ;
endmodule

// File: tb/tb_ps2_key_mapper.sv
// Bench for ps2_key_mapper: a 2-octave and a 1-octave instance fed the same bytes,
// expected outputs queued per byte from a flag-based reference model.
module tb_ps2_key_mapper;
  localparam int TMO = 100;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  ps2_key_mapper_if #(.OCTAVES(2)) bus2 ();
  ps2_key_mapper_if #(.OCTAVES(1)) bus1 ();

  ps2_key_mapper #(.OCTAVES(2), .TIMEOUT_CYCLES(TMO)) dut2 (.mclk(mclk), .rst(rst), .bus(bus2));
  ps2_key_mapper #(.OCTAVES(1), .TIMEOUT_CYCLES(TMO)) dut1 (.mclk(mclk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [23:0] keys2;
    logic        ev2;
    logic [4:0]  idx2;
    logic        press2;
    logic [11:0] keys1;
    logic        ev1;
    logic [7:0]  last;
    logic [7:0]  prev;
  } exp_t;

  exp_t expQ[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   evCount = 0;
  int   evBase;

  logic [7:0] noteCodes [24] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
                                 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26,
                                 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C};

  // Reference model state
  logic        mBrk, mExt;
  logic [23:0] mKeys2;
  logic [11:0] mKeys1;
  logic [4:0]  mIdx;
  logic        mPress;
  logic [7:0]  mLast, mPrev;

  // Count keyEvent pulses on the 2-octave instance, sampled mid-cycle.
  always @(negedge mclk) if (bus2.keyEvent === 1'b1) evCount++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int noteOf(input logic [7:0] code);
    for (int i = 0; i < 24; i++) if (noteCodes[i] == code) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mBrk = 0; mExt = 0; mKeys2 = '0; mKeys1 = '0;
    mIdx = '0; mPress = 0; mLast = '0; mPrev = '0;
  endtask

  function automatic exp_t snapshot(input logic ev2, input logic ev1);
    exp_t e;
    e.keys2 = mKeys2; e.ev2 = ev2; e.idx2 = mIdx; e.press2 = mPress;
    e.keys1 = mKeys1; e.ev1 = ev1; e.last = mLast; e.prev = mPrev;
    return e;
  endfunction

  task automatic modelByte(input logic [7:0] b);
    int n;
    logic ev2, ev1;
    ev2 = 0; ev1 = 0;
    mPrev = mLast; mLast = b;
    if (b == 8'hF0) mBrk = 1;
    else if (b == 8'hE0) mExt = 1;
    else begin
      n = noteOf(b);
      if (!mExt && n >= 0) begin
        if (mKeys2[n] == mBrk) begin
          mKeys2[n] = !mBrk; ev2 = 1; mIdx = 5'(n); mPress = !mBrk;
        end
        if (n < 12 && mKeys1[n] == mBrk) begin
          mKeys1[n] = !mBrk; ev1 = 1;
        end
      end
      mBrk = 0; mExt = 0;
    end
    expQ.push_back(snapshot(ev2, ev1));
  endtask

  task automatic checkOutputs(input string tag, input exp_t e);
    check({tag, ".keys2"},  32'(bus2.keys),       32'(e.keys2));
    check({tag, ".ev2"},    32'(bus2.keyEvent),   32'(e.ev2));
    check({tag, ".idx2"},   32'(bus2.eventIndex), 32'(e.idx2));
    check({tag, ".press2"}, 32'(bus2.eventPress), 32'(e.press2));
    check({tag, ".last"},   32'(bus2.lastCode),   32'(e.last));
    check({tag, ".prev"},   32'(bus2.prevCode),   32'(e.prev));
    check({tag, ".keys1"},  32'(bus1.keys),       32'(e.keys1));
    check({tag, ".ev1"},    32'(bus1.keyEvent),   32'(e.ev1));
  endtask

  // Present one byte for one cycle, check the registered result, then the pulse drop.
  task automatic sendByte(input logic [7:0] b);
    exp_t e;
    bus2.dataValid = 1; bus2.dataIn = b;
    bus1.dataValid = 1; bus1.dataIn = b;
    modelByte(b);
    @(posedge mclk); #1;
    bus2.dataValid = 0; bus1.dataValid = 0;
    e = expQ.pop_front();
    checkOutputs($sformatf("byte%02h", b), e);
    @(posedge mclk); #1;
    check("pulse2", 32'(bus2.keyEvent), 32'd0);
    check("pulse1", 32'(bus1.keyEvent), 32'd0);
  endtask

  // Reset while a byte is also offered: reset must win.
  task automatic doReset();
    rst = 1;
    bus2.dataValid = 1; bus2.dataIn = 8'h1A;
    bus1.dataValid = 1; bus1.dataIn = 8'h1A;
    @(posedge mclk); #1;
    rst = 0; bus2.dataValid = 0; bus1.dataValid = 0;
    modelReset();
    checkOutputs("reset", snapshot(1'b0, 1'b0));
  endtask

  initial begin
    bus2.dataValid = 0; bus2.dataIn = '0;
    bus1.dataValid = 0; bus1.dataIn = '0;
    modelReset();
    @(posedge mclk); #1;
    doReset();

    // 1: single make
    sendByte(8'h1A);
    check("t1.keys", 32'(bus2.keys), 32'h000001);

    // 2: break of the same key
    sendByte(8'hF0); sendByte(8'h1A);
    check("t2.keys", 32'(bus2.keys), 32'h0);
    check("t2.prev", 32'(bus2.prevCode), 32'hF0);

    // 3: chord plus typematic repeat
    doReset();
    evBase = evCount;
    sendByte(8'h15); sendByte(8'h3C); sendByte(8'h1A); sendByte(8'h1A);
    check("t3.keys", 32'(bus2.keys), 32'h801001);
    check("t3.events", evCount - evBase, 3);
    sendByte(8'hF0); sendByte(8'h15);
    check("t3.rel", 32'(bus2.keys), 32'h800001);

    // 4: extended codes never touch keys; break of a non-held key is silent
    doReset();
    evBase = evCount;
    sendByte(8'hE0); sendByte(8'h1A);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h1A);
    sendByte(8'hF0); sendByte(8'h22);
    foreach (noteCodes[i]) if (i < 5) sendByte(i == 0 ? 8'hAA : i == 1 ? 8'hEE :
                                               i == 2 ? 8'hFA : i == 3 ? 8'hFC : 8'hFE);
    check("t4.keys", 32'(bus2.keys), 32'h0);
    check("t4.events", evCount - evBase, 0);
    sendByte(8'hF0);
    doReset();
    sendByte(8'h1A);
    check("t4.prefixDrop", 32'(bus2.keys), 32'h1);

    // 5: octave-1 code on the 1-octave instance; break of a clear bit
    doReset();
    sendByte(8'h15);
    check("t5.keys1", 32'(bus1.keys), 32'h000);
    sendByte(8'hF0); sendByte(8'h3A);
    check("t5.keys1b", 32'(bus1.keys), 32'h000);
    sendByte(8'h3A);
    check("t5.top1", 32'(bus1.keys), 32'h800);

`ifdef PS2_KEY_TIMEOUT_EN
    // 6: idle auto-release
    doReset();
    sendByte(8'h1A);
    repeat (TMO - 2) @(posedge mclk);
    #1;
    check("t6.held", 32'(bus2.keys), 32'h1);
    @(posedge mclk); #1;
    check("t6.released", 32'(bus2.keys), 32'h0);
    check("t6.noEvent", 32'(bus2.keyEvent), 32'd0);
    check("t6.released1", 32'(bus1.keys), 32'h0);
    modelReset();
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
